sram_arbiter: RTL and testbench

Sequences the single asynchronous 16-bit SRAM (1M x 16) and shares it between two requesters: the drawing engine (read-only, port 0) and the sprite/level loader (read/write, port 1). Sits between the requesters and the board SRAM pins. Drives registered active-low chip controls, returns read data with a valid pulse, and owns the data-bus direction.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_grant.sv | 40 ++++
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
// Widths match the board's 1M x 16 asynchronous SRAM.
package sram_pkg;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_RECOVER = 2'd3
    } sram_state_t;

    localparam logic PORT_DRAW = 1'b0;
    localparam logic PORT_LOAD = 1'b1;
endpackage

// File: rtl/sram_grant.sv
// Two-port grant decision. Fixed priority (draw port wins) by default;
// define SRAM_ROUND_ROBIN_EN to alternate on ties using a last-grant pointer.
module sram_grant
    import sram_pkg::*;
(
    input  logic Clk,
    input  logic Reset_n,
    input  logic req_draw,
    input  logic req_load,
    input  logic grant_en,
    output logic grant_port
);

`ifdef SRAM_ROUND_ROBIN_EN
    logic last_port;

    always_comb begin
        grant_port = PORT_LOAD;
        if (req_draw && req_load) begin
            grant_port = ~last_port;
        end else if (req_draw) begin
            grant_port = PORT_DRAW;
        end
    end

    // Reset to "last = load" so the draw port wins the first tie.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_port <= PORT_LOAD;
        end else if (grant_en) begin
            last_port <= grant_port;
        end
    end
`else
    logic unused_rr;
    assign unused_rr  = ^{Clk, Reset_n, req_load, grant_en};
    assign grant_port = req_draw ? PORT_DRAW : PORT_LOAD;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares the asynchronous SRAM between the drawing engine (port 0, read-only)
// and the loader (port 1, read/write). Optional macro: SRAM_ROUND_ROBIN_EN.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | bus quiet, arbitrate incoming requests
//   ST_ACCESS  | CE low, WAIT_STATES+1 cycles of read or write strobe
//   ST_SAMPLE  | read data presented with Valid; also arbitrates
//   ST_RECOVER | write hold: WE high, CE low, data still driven
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   R0_Req,
    input  logic [SRAM_ADDR_W-1:0] R0_Addr,
    output logic                   R0_Ack,
    output logic [SRAM_DATA_W-1:0] R0_Rdata,
    output logic                   R0_Valid,
    input  logic                   R1_Req,
    input  logic                   R1_WE,
    input  logic [SRAM_ADDR_W-1:0] R1_Addr,
    input  logic [SRAM_DATA_W-1:0] R1_Wdata,
    input  logic [1:0]             R1_BE,
    output logic                   R1_Ack,
    output logic [SRAM_DATA_W-1:0] R1_Rdata,
    output logic                   R1_Valid,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
    output logic                   SRAM_DQ_oe
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

    sram_state_t            state;
    logic [2:0]             wait_cnt;
    logic                   cur_port;
    logic                   cur_we;
    logic                   grant_en;
    logic                   gnt_port;
    logic                   gnt_we;
    logic [1:0]             gnt_be;
    logic [SRAM_ADDR_W-1:0] gnt_addr;

    // SAMPLE arbitrates like IDLE so back-to-back reads run every W+2 cycles.
    assign grant_en = ((state == ST_IDLE) || (state == ST_SAMPLE)) && (R0_Req || R1_Req);
    assign gnt_we   = (gnt_port == PORT_LOAD) && R1_WE;
    assign gnt_be   = (gnt_port == PORT_LOAD) ? R1_BE : 2'b11;
    assign gnt_addr = (gnt_port == PORT_LOAD) ? R1_Addr : R0_Addr;

    sram_grant u_grant (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_draw   (R0_Req),
        .req_load   (R1_Req),
        .grant_en   (grant_en),
        .grant_port (gnt_port)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            cur_port    <= PORT_DRAW;
            cur_we      <= 1'b0;
            R0_Ack      <= 1'b0;
            R1_Ack      <= 1'b0;
            R0_Valid    <= 1'b0;
            R1_Valid    <= 1'b0;
            R0_Rdata    <= '0;
            R1_Rdata    <= '0;
            SRAM_ADDR   <= '0;
            SRAM_CE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
        end else begin
            R0_Ack   <= 1'b0;
            R1_Ack   <= 1'b0;
            R0_Valid <= 1'b0;
            R1_Valid <= 1'b0;
            case (state)
                ST_IDLE, ST_SAMPLE: begin
                    if (grant_en) begin
                        state     <= ST_ACCESS;
                        wait_cnt  <= WAIT_CNT;
                        cur_port  <= gnt_port;
                        cur_we    <= gnt_we;
                        R0_Ack    <= (gnt_port == PORT_DRAW);
                        R1_Ack    <= (gnt_port == PORT_LOAD);
                        SRAM_ADDR <= gnt_addr;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= gnt_we;
                        // All-zero byte enables turn a write into a bus no-op.
                        SRAM_WE_N  <= ~(gnt_we && (|gnt_be));
                        SRAM_UB_N  <= ~gnt_be[1];
                        SRAM_LB_N  <= ~gnt_be[0];
                        SRAM_DQ_oe <= gnt_we;
                        if (gnt_we) begin
                            SRAM_DQ_out <= R1_Wdata;
                        end
                    end else begin
                        state      <= ST_IDLE;
                        SRAM_CE_N  <= 1'b1;
                        SRAM_OE_N  <= 1'b1;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_UB_N  <= 1'b1;
                        SRAM_LB_N  <= 1'b1;
                        SRAM_DQ_oe <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else if (cur_we) begin
                        state     <= ST_RECOVER;
                        SRAM_WE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        R1_Valid  <= 1'b1;
                    end else begin
                        state     <= ST_SAMPLE;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_UB_N <= 1'b1;
                        SRAM_LB_N <= 1'b1;
                        if (cur_port == PORT_DRAW) begin
                            R0_Rdata <= SRAM_DQ_in;
                            R0_Valid <= 1'b1;
                        end else begin
                            R1_Rdata <= SRAM_DQ_in;
                            R1_Valid <= 1'b1;
                        end
                    end
                end
                ST_RECOVER: begin
                    state      <= ST_IDLE;
                    SRAM_CE_N  <= 1'b1;
                    SRAM_DQ_oe <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed transactions push expectations,
// negedge monitors pop them on every Valid and count SRAM pin activity.
module tb_sram_arbiter;
    localparam int W = 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
        bit          is_wr;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        R0_Req, R1_Req, R1_WE;
    logic [19:0] R0_Addr, R1_Addr;
    logic [15:0] R1_Wdata;
    logic [1:0]  R1_BE;
    logic        R0_Ack, R0_Valid, R1_Ack, R1_Valid;
    logic [15:0] R0_Rdata, R1_Rdata;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in = 16'h0, SRAM_DQ_out;

    logic        b_r0_req;
    logic [19:0] b_r0_addr;
    logic        b_r0_ack, b_r0_valid, b_r1_ack, b_r1_valid;
    logic [15:0] b_r0_rdata, b_r1_rdata, b_dq_out;
    logic [15:0] b_dq_in = 16'h0;
    logic [19:0] b_addr;
    logic        b_ce_n, b_ub_n, b_lb_n, b_oe_n, b_we_n, b_dq_oe;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int n_ce_oe = 0, n_we = 0, n_ub = 0, n_lb = 0, n_dqoe = 0, n_r1_act = 0, n_valid = 0;
    int n_clash = 0, b_clash = 0, b_prev = -1, b_r1_act = 0;
    int s_ce_oe, s_we, s_ub, s_lb, s_dqoe, s_r1_act, s_valid;
    exp_t        exp0[$], exp1[$];
    logic [15:0] expb[$];
    int          ack_log[$];
    logic [15:0] mem [logic [19:0]];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    sram_arbiter #(.WAIT_STATES(W)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .R0_Req(R0_Req), .R0_Addr(R0_Addr), .R0_Ack(R0_Ack), .R0_Rdata(R0_Rdata), .R0_Valid(R0_Valid),
        .R1_Req(R1_Req), .R1_WE(R1_WE), .R1_Addr(R1_Addr), .R1_Wdata(R1_Wdata), .R1_BE(R1_BE),
        .R1_Ack(R1_Ack), .R1_Rdata(R1_Rdata), .R1_Valid(R1_Valid),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_DQ_in(SRAM_DQ_in),
        .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe)
    );

    sram_arbiter #(.WAIT_STATES(0)) u_dut_w0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .R0_Req(b_r0_req), .R0_Addr(b_r0_addr), .R0_Ack(b_r0_ack), .R0_Rdata(b_r0_rdata), .R0_Valid(b_r0_valid),
        .R1_Req(1'b0), .R1_WE(1'b0), .R1_Addr(20'h0), .R1_Wdata(16'h0), .R1_BE(2'b00),
        .R1_Ack(b_r1_ack), .R1_Rdata(b_r1_rdata), .R1_Valid(b_r1_valid),
        .SRAM_ADDR(b_addr), .SRAM_CE_N(b_ce_n), .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n),
        .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n), .SRAM_DQ_in(b_dq_in),
        .SRAM_DQ_out(b_dq_out), .SRAM_DQ_oe(b_dq_oe)
    );

    function automatic logic [15:0] rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 16'hDEAD;
    endfunction

    // SRAM model: byte-lane writes at the clock edge, read data settled by the negedge.
    always @(posedge Clk) begin
        logic [15:0] nv;
        if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) begin
            nv = rd(SRAM_ADDR);
            if (!SRAM_UB_N) nv[15:8] = SRAM_DQ_out[15:8];
            if (!SRAM_LB_N) nv[7:0]  = SRAM_DQ_out[7:0];
            mem[SRAM_ADDR] = nv;
        end
    end

    always @(negedge Clk) begin
        SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? rd(SRAM_ADDR) : 16'h0000;
        b_dq_in    = (!b_ce_n && !b_oe_n) ? (b_addr[15:0] ^ 16'hA5A5) : 16'h0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!SRAM_CE_N && !SRAM_OE_N) n_ce_oe++;
        if (!SRAM_WE_N) n_we++;
        if (!SRAM_UB_N) n_ub++;
        if (!SRAM_LB_N) n_lb++;
        if (SRAM_DQ_oe) n_dqoe++;
        if (!SRAM_OE_N && SRAM_DQ_oe) n_clash++;
        if (R1_Ack || R1_Valid) n_r1_act++;
        if (R0_Valid || R1_Valid) n_valid++;
        if (R0_Ack) ack_log.push_back(0);
        if (R1_Ack) ack_log.push_back(1);
        if (R0_Valid) begin
            if (exp0.size() == 0) chk("r0_valid_unexpected", exp0.size(), 1);
            else begin
                e = exp0.pop_front();
                chk("r0_rdata", R0_Rdata, e.data);
                if (e.cyc >= 0) chk("r0_valid_cycle", cyc, e.cyc);
            end
        end
        if (R1_Valid) begin
            if (exp1.size() == 0) chk("r1_valid_unexpected", exp1.size(), 1);
            else begin
                e = exp1.pop_front();
                if (!e.is_wr) chk("r1_rdata", R1_Rdata, e.data);
                if (e.cyc >= 0) chk("r1_valid_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge Clk) begin
        if (!b_oe_n && b_dq_oe) b_clash++;
        if (b_r1_ack || b_r1_valid) b_r1_act++;
        if (b_r0_valid) begin
            if (expb.size() == 0) chk("b2b_valid_unexpected", expb.size(), 1);
            else chk("b2b_rdata", b_r0_rdata, expb.pop_front());
            if (b_prev >= 0) chk("b2b_period", cyc - b_prev, 2);
            b_prev = cyc;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic snap();
        s_ce_oe = n_ce_oe; s_we = n_we; s_ub = n_ub; s_lb = n_lb;
        s_dqoe = n_dqoe; s_r1_act = n_r1_act; s_valid = n_valid;
    endtask

    task automatic wait_ack(input bit port, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (port ? R1_Ack : R0_Ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic txn(input bit port, input bit we, input logic [19:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be,
                       input logic [15:0] expd, input bit timed);
        exp_t e;
        int   t0;
        bit   got;
        t0 = cyc;
        e.data = expd; e.cyc = timed ? t0 + W + 2 : -1; e.is_wr = we;
        if (port) begin
            exp1.push_back(e);
            R1_Req = 1'b1; R1_WE = we; R1_Addr = addr; R1_Wdata = wdata; R1_BE = be;
        end else begin
            exp0.push_back(e);
            R0_Req = 1'b1; R0_Addr = addr;
        end
        wait_ack(port, got);
        if (port) R1_Req = 1'b0; else R0_Req = 1'b0;
        chk("ack_seen", got, 1);
        if (timed) chk("ack_cycle", cyc, t0 + 1);
    endtask

    task automatic hold2(input bit port, input logic [19:0] a0, input logic [19:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        exp_t e;
        bit   got;
        e.cyc = -1; e.is_wr = 1'b0;
        e.data = d0; if (port) exp1.push_back(e); else exp0.push_back(e);
        e.data = d1; if (port) exp1.push_back(e); else exp0.push_back(e);
        if (port) begin R1_Req = 1'b1; R1_WE = 1'b0; R1_BE = 2'b11; R1_Addr = a0; end
        else begin R0_Req = 1'b1; R0_Addr = a0; end
        wait_ack(port, got);
        chk("hold_ack0", got, 1);
        if (port) R1_Addr = a1; else R0_Addr = a1;
        wait_ack(port, got);
        chk("hold_ack1", got, 1);
        if (port) R1_Req = 1'b0; else R0_Req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit got;
        int ord [4];
        bit tie_first;
`ifdef SRAM_ROUND_ROBIN_EN
        ord = '{0, 1, 0, 1};
        tie_first = 1'b1;
`else
        ord = '{0, 0, 1, 1};
        tie_first = 1'b0;
`endif
        mem[20'h00010] = 16'hBEEF; mem[20'hFFFFF] = 16'h0000; mem[20'h00020] = 16'h2020;
        mem[20'h00030] = 16'h0000; mem[20'h00040] = 16'h4040; mem[20'h00041] = 16'h4141;
        mem[20'h00050] = 16'h5050; mem[20'h00051] = 16'h5151; mem[20'h00060] = 16'h6060;
        Reset_n = 1'b0; R0_Req = 0; R1_Req = 0; R1_WE = 0; R0_Addr = '0; R1_Addr = '0;
        R1_Wdata = '0; R1_BE = '0; b_r0_req = 0; b_r0_addr = '0;
        settle(3);
        chk("rst_ctrl_n", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N}, 5'h1f);
        chk("rst_dq_oe", SRAM_DQ_oe, 0);
        chk("rst_ack_valid", {R0_Ack, R1_Ack, R0_Valid, R1_Valid}, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_rdata", {R0_Rdata, R1_Rdata}, 0);
        Reset_n = 1'b1;
        settle(2);

        snap();
        txn(0, 0, 20'h00010, 16'h0, 2'b11, 16'hBEEF, 1);
        settle(6);
        chk("rd_ce_oe_cycles", n_ce_oe - s_ce_oe, W + 1);
        chk("rd_r1_quiet", n_r1_act - s_r1_act, 0);
        chk("rd_we_cycles", n_we - s_we, 0);

        snap();
        txn(1, 1, 20'hFFFFF, 16'h1234, 2'b10, 16'h0, 1);
        settle(6);
        chk("wr_we_cycles", n_we - s_we, W + 1);
        chk("wr_ub_cycles", n_ub - s_ub, W + 1);
        chk("wr_lb_cycles", n_lb - s_lb, 0);
        chk("wr_dqoe_cycles", n_dqoe - s_dqoe, W + 2);
        txn(1, 0, 20'hFFFFF, 16'h0, 2'b11, 16'h1200, 1);
        settle(5);

        snap();
        txn(1, 1, 20'h00010, 16'h5555, 2'b00, 16'h0, 1);
        settle(6);
        chk("be0_we_cycles", n_we - s_we, 0);
        chk("be0_ub_cycles", n_ub - s_ub, 0);
        chk("be0_lb_cycles", n_lb - s_lb, 0);
        txn(0, 0, 20'h00010, 16'h0, 2'b11, 16'hBEEF, 1);
        settle(5);
        chk("r0_rdata_hold", R0_Rdata, 16'hBEEF);

        base = ack_log.size();
        fork
            txn(0, 0, 20'h00020, 16'h0, 2'b11, 16'h2020, 0);
            txn(1, 1, 20'h00030, 16'hCAFE, 2'b11, 16'h0, 0);
        join
        settle(8);
        chk("tie_ack_count", ack_log.size() - base, 2);
        chk("tie_first", ack_log[base], {31'b0, tie_first});
        chk("tie_second", ack_log[base + 1], {31'b0, ~tie_first});
        txn(1, 0, 20'h00030, 16'h0, 2'b11, 16'hCAFE, 0);
        settle(5);

        base = ack_log.size();
        fork
            hold2(0, 20'h00040, 20'h00041, 16'h4040, 16'h4141);
            hold2(1, 20'h00050, 20'h00051, 16'h5050, 16'h5151);
        join
        settle(8);
        chk("hold_ack_count", ack_log.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("hold_order", ack_log[base + i], ord[i]);

        snap();
        R1_Req = 1'b1; R1_WE = 1'b1; R1_Addr = 20'h00060; R1_Wdata = 16'h9999; R1_BE = 2'b11;
        wait_ack(1, got);
        R1_Req = 1'b0;
        chk("rstmid_ack", got, 1);
        chk("rstmid_in_write", SRAM_WE_N, 0);
        Reset_n = 1'b0;
        #1;
        chk("rstmid_ctrl_n", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N}, 5'h1f);
        chk("rstmid_dq_oe", SRAM_DQ_oe, 0);
        chk("rstmid_addr", SRAM_ADDR, 0);
        chk("rstmid_ack_valid", {R0_Ack, R1_Ack, R0_Valid, R1_Valid}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        settle(6);
        chk("rstmid_no_valid", n_valid - s_valid, 0);
        txn(0, 0, 20'h00060, 16'h0, 2'b11, 16'h6060, 1);
        settle(5);

        for (int i = 1; i <= 4; i++) begin
            expb.push_back(16'(i) ^ 16'hA5A5);
            b_r0_req = 1'b1;
            b_r0_addr = 20'(i);
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge Clk);
                if (b_r0_ack) begin got = 1'b1; break; end
            end
            chk("b2b_ack", got, 1);
        end
        b_r0_req = 1'b0;
        settle(6);

        chk("pending_r0", exp0.size(), 0);
        chk("pending_r1", exp1.size(), 0);
        chk("pending_b2b", expb.size(), 0);
        chk("dir_clash", n_clash, 0);
        chk("b2b_dir_clash", b_clash, 0);
        chk("b2b_r1_quiet", b_r1_act, 0);
        chk("b2b_idle_ctrl_n", {b_ce_n, b_ub_n, b_lb_n, b_oe_n, b_we_n}, 5'h1f);
        chk("b2b_no_write_data", {b_dq_out, b_r1_rdata}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
